// File: rtl/robot_pkg.sv
// Shared drive-command codes and arbiter mode encoding for the robot datapath.
package robot_pkg;

  typedef enum logic [4:0] {
    STOP  = 5'b00000,
    FWD   = 5'b00001,
    REV   = 5'b00010,
    LEFT  = 5'b00100,
    RIGHT = 5'b01000,
    SPIN  = 5'b10000
  } motor_cmd_t;

  typedef enum logic [1:0] {
    AUTO   = 2'd0,
    MANUAL = 2'd1,
    SAFETY = 2'd2
  } arb_mode_t;

  localparam int unsigned CMD_W = 5;

  // True for the six defined drive codes; anything else is driven as STOP.
  function automatic logic cmd_is_valid(input logic [CMD_W-1:0] c);
    return (c == STOP) || (c == FWD) || (c == REV) ||
           (c == LEFT) || (c == RIGHT) || (c == SPIN);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/motor_cmd_arbiter.sv
// Selects the motor drive command from safety, IR-manual and autonomous sources
// and inserts a STOP dead time on every direct direction change.
module motor_cmd_arbiter
  import robot_pkg::*;
#(
  parameter int unsigned MANUAL_HOLD  = 25_000_000,
  parameter int unsigned DEAD_CYCLES  = 500_000,
  parameter int unsigned CLEAR_CYCLES = 2_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] fsm_cmd,
  input  logic       ir_valid,
  input  logic [4:0] ir_cmd,
  input  logic       proximity,
  output logic [4:0] motor_cmd,
  output logic [1:0] mode,
  output logic       dead_active
);

  localparam int unsigned MW = (MANUAL_HOLD  > 0) ? $clog2(MANUAL_HOLD + 1)  : 1;
  localparam int unsigned DW = (DEAD_CYCLES  > 0) ? $clog2(DEAD_CYCLES + 1)  : 1;
  localparam int unsigned CW = (CLEAR_CYCLES > 0) ? $clog2(CLEAR_CYCLES + 1) : 1;

  typedef enum logic [0:0] {RUN = 1'b0, DEAD = 1'b1} state_t;

  logic          prox_s;
  logic [4:0]    ir_cmd_q, ir_cmd_d;
  logic [MW-1:0] manual_cnt_q, manual_cnt_d;
  logic [CW-1:0] clear_cnt_q, clear_cnt_d;
  logic [DW-1:0] dead_cnt_q, dead_cnt_d;
  state_t        state_q, state_d;
  logic [4:0]    motor_cmd_q, motor_cmd_d;
  arb_mode_t     mode_q, mode_d;
  logic          dead_active_q, dead_active_d;

  logic          manual_active;
  logic          fwd_blocked;
  logic [4:0]    req;
  logic [4:0]    target;

  sync2 u_prox_sync (
    .clk   (clk),
    .reset (reset),
    .d     (proximity),
    .q     (prox_s)
  );

  // Manual latch and safety clear-hold counters; a reload beats a decrement.
  always_comb begin
    ir_cmd_d     = ir_cmd_q;
    manual_cnt_d = manual_cnt_q;
    clear_cnt_d  = clear_cnt_q;
    if (ir_valid) begin
      ir_cmd_d     = ir_cmd;
      manual_cnt_d = MW'(MANUAL_HOLD);
    end else if (manual_cnt_q != '0) begin
      manual_cnt_d = manual_cnt_q - MW'(1);
    end
    if (prox_s) begin
      clear_cnt_d = CW'(CLEAR_CYCLES);
    end else if (clear_cnt_q != '0) begin
      clear_cnt_d = clear_cnt_q - CW'(1);
    end
  end

  // Request/target selection and next mode.
  always_comb begin
    manual_active = (manual_cnt_q != '0);
    fwd_blocked   = prox_s | (clear_cnt_q != '0);
    req           = manual_active ? ir_cmd_q : fsm_cmd;
    target        = req;
    if (!cmd_is_valid(req) || ((req == FWD) && fwd_blocked)) begin
      target = STOP;
    end
    if (fwd_blocked && (req == FWD)) begin
      mode_d = SAFETY;
    end else if (manual_active) begin
      mode_d = MANUAL;
    end else begin
      mode_d = AUTO;
    end
  end

  // Output FSM: direct changes through STOP are immediate, reversals get dead time.
  always_comb begin
    state_d     = state_q;
    motor_cmd_d = motor_cmd_q;
    dead_cnt_d  = dead_cnt_q;
    case (state_q)
      RUN: begin
        if (target != motor_cmd_q) begin
          if ((target == STOP) || (motor_cmd_q == STOP)) begin
            motor_cmd_d = target;
          end else begin
            motor_cmd_d = STOP;
            dead_cnt_d  = DW'(DEAD_CYCLES - 1);
            state_d     = DEAD;
          end
        end
      end
      DEAD: begin
        if (dead_cnt_q != '0) begin
          dead_cnt_d = dead_cnt_q - DW'(1);
        end else begin
          motor_cmd_d = target;
          state_d     = RUN;
        end
      end
      default: begin
        motor_cmd_d = STOP;
        state_d     = RUN;
      end
    endcase
    dead_active_d = (state_d == DEAD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_cmd_q      <= '0;
      manual_cnt_q  <= '0;
      clear_cnt_q   <= '0;
      dead_cnt_q    <= '0;
      state_q       <= RUN;
      motor_cmd_q   <= STOP;
      mode_q        <= AUTO;
      dead_active_q <= 1'b0;
    end else begin
      ir_cmd_q      <= ir_cmd_d;
      manual_cnt_q  <= manual_cnt_d;
      clear_cnt_q   <= clear_cnt_d;
      dead_cnt_q    <= dead_cnt_d;
      state_q       <= state_d;
      motor_cmd_q   <= motor_cmd_d;
      mode_q        <= mode_d;
      dead_active_q <= dead_active_d;
    end
  end

  assign motor_cmd   = motor_cmd_q;
  assign mode        = mode_q;
  assign dead_active = dead_active_q;

endmodule

// File: tb/tb_motor_cmd_arbiter.sv
// Directed self-checking bench for motor_cmd_arbiter with small timing parameters.
module tb_motor_cmd_arbiter;
  import robot_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] fsm_cmd;
  logic       ir_valid;
  logic [4:0] ir_cmd;
  logic       proximity;
  logic [4:0] motor_cmd;
  logic [1:0] mode;
  logic       dead_active;

  int checks   = 0;
  int failures = 0;

  motor_cmd_arbiter #(
    .MANUAL_HOLD  (20),
    .DEAD_CYCLES  (4),
    .CLEAR_CYCLES (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fsm_cmd     (fsm_cmd),
    .ir_valid    (ir_valid),
    .ir_cmd      (ir_cmd),
    .proximity   (proximity),
    .motor_cmd   (motor_cmd),
    .mode        (mode),
    .dead_active (dead_active)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle past the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ir_pulse(input logic [4:0] c);
    ir_valid = 1'b1;
    ir_cmd   = c;
    tick();
    ir_valid = 1'b0;
  endtask

  initial begin
    logic [4:0] exp_cmd;
    logic [1:0] exp_mode;

    reset = 1'b1; fsm_cmd = FWD; ir_valid = 1'b0; ir_cmd = STOP; proximity = 1'b0;
    repeat (3) tick();
    check_eq("rst_cmd", 8'(motor_cmd), 8'(STOP));
    check_eq("rst_mode", 8'(mode), 8'(AUTO));
    check_eq("rst_dead", 8'(dead_active), 8'd0);

    reset = 1'b0;
    tick();
    check_eq("rel_fwd", 8'(motor_cmd), 8'(FWD));
    check_eq("rel_mode", 8'(mode), 8'(AUTO));

    // Direct reversal FWD -> REV
    fsm_cmd = REV;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_eq("rev_dead_cmd", 8'(motor_cmd), 8'(STOP));
      check_eq("rev_dead_flag", 8'(dead_active), 8'd1);
    end
    tick();
    check_eq("rev_cmd", 8'(motor_cmd), 8'(REV));
    check_eq("rev_flag", 8'(dead_active), 8'd0);

    // Passing through STOP needs no dead time
    fsm_cmd = STOP; tick();
    fsm_cmd = FWD;  tick();
    check_eq("stop_fwd", 8'(motor_cmd), 8'(FWD));
    fsm_cmd = STOP; tick();
    check_eq("fwd_stop", 8'(motor_cmd), 8'(STOP));
    fsm_cmd = REV;  tick();
    check_eq("stop_rev", 8'(motor_cmd), 8'(REV));
    check_eq("stop_rev_flag", 8'(dead_active), 8'd0);
    fsm_cmd = STOP; tick();
    fsm_cmd = FWD;  tick();
    check_eq("back_fwd", 8'(motor_cmd), 8'(FWD));

    // Manual LEFT over auto FWD, then expiry
    ir_pulse(LEFT);
    check_eq("man_e0_cmd", 8'(motor_cmd), 8'(FWD));
    check_eq("man_e0_mode", 8'(mode), 8'(AUTO));
    for (int k = 1; k <= 25; k++) begin
      tick();
      exp_cmd  = (k <= 4) ? STOP : (k <= 20) ? LEFT : (k <= 24) ? STOP : FWD;
      exp_mode = (k <= 20) ? MANUAL : AUTO;
      check_eq("man_cmd", 8'(motor_cmd), 8'(exp_cmd));
      check_eq("man_mode", 8'(mode), 8'(exp_mode));
    end

    // Manual re-pulse at cycle 19 extends the hold
    ir_pulse(LEFT);
    for (int k = 1; k <= 44; k++) begin
      if (k == 19) begin
        ir_pulse(LEFT);
      end else begin
        tick();
      end
      exp_cmd  = (k <= 4) ? STOP : (k <= 39) ? LEFT : (k <= 43) ? STOP : FWD;
      exp_mode = (k <= 39) ? MANUAL : AUTO;
      check_eq("ext_cmd", 8'(motor_cmd), 8'(exp_cmd));
      check_eq("ext_mode", 8'(mode), 8'(exp_mode));
    end

    // Proximity rise blocks FWD after synchronizer + output register
    proximity = 1'b1;
    tick(); check_eq("prox_e1", 8'(motor_cmd), 8'(FWD));
    tick(); check_eq("prox_e2", 8'(motor_cmd), 8'(FWD));
    tick();
    check_eq("prox_e3", 8'(motor_cmd), 8'(STOP));
    check_eq("prox_mode", 8'(mode), 8'(SAFETY));
    fsm_cmd = REV; tick();
    check_eq("prox_rev", 8'(motor_cmd), 8'(REV));
    check_eq("prox_rev_flag", 8'(dead_active), 8'd0);
    check_eq("prox_rev_mode", 8'(mode), 8'(AUTO));
    fsm_cmd = FWD; tick();
    check_eq("prox_fwd_blk", 8'(motor_cmd), 8'(STOP));
    check_eq("prox_fwd_mode", 8'(mode), 8'(SAFETY));

    // Proximity fall: FWD re-allowed after sync + clear hold
    proximity = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      exp_cmd  = (k <= 10) ? STOP : FWD;
      exp_mode = (k <= 10) ? SAFETY : AUTO;
      check_eq("clr_cmd", 8'(motor_cmd), 8'(exp_cmd));
      check_eq("clr_mode", 8'(mode), 8'(exp_mode));
    end

    // Invalid code and move from STOP
    fsm_cmd = 5'b00011; tick();
    check_eq("inv_cmd", 8'(motor_cmd), 8'(STOP));
    check_eq("inv_flag", 8'(dead_active), 8'd0);
    fsm_cmd = RIGHT; tick();
    check_eq("right_cmd", 8'(motor_cmd), 8'(RIGHT));

    // Reset in the middle of dead time while manual and clear-hold are active
    proximity = 1'b1; tick();
    proximity = 1'b0;
    ir_pulse(LEFT);
    tick();
    check_eq("mid_e1_cmd", 8'(motor_cmd), 8'(STOP));
    check_eq("mid_e1_mode", 8'(mode), 8'(MANUAL));
    tick();
    check_eq("mid_e2_flag", 8'(dead_active), 8'd1);
    reset = 1'b1; fsm_cmd = FWD;
    tick();
    check_eq("mrst_cmd", 8'(motor_cmd), 8'(STOP));
    check_eq("mrst_flag", 8'(dead_active), 8'd0);
    check_eq("mrst_mode", 8'(mode), 8'(AUTO));
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_eq("post_cmd", 8'(motor_cmd), 8'(FWD));
      check_eq("post_mode", 8'(mode), 8'(AUTO));
      check_eq("post_flag", 8'(dead_active), 8'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
